// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first and
// hands them out over a registered valid/ready port, stalling the serial source when full.
module serial_deserializer #(
    parameter int WIDTH = 64,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic             serial_ready,
    input  logic             shift_dir,
    input  logic             sync_clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [CW-1:0]    bit_count,
    output logic             frame_err
);

    typedef enum logic {COLLECT, STALL} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  asm_q, asm_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              order_q, order_d;
    logic [CW-1:0]     bit_count_q, bit_count_d;

    logic              accept;
    logic              last_bit;
    logic              out_free;
    logic              cur_order;
    logic [WIDTH-1:0]  shifted;

    assign serial_ready = !rst && (state_q == COLLECT);
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign bit_count    = bit_count_q;
    assign frame_err    = frame_err_q;

    // Bit order is taken live on the first bit of a word, then held for the rest of it.
    always_comb begin
        accept    = serial_valid && serial_ready;
        cur_order = (bit_count_q == '0) ? shift_dir : order_q;
        shifted   = cur_order ? {serial_in, asm_q[WIDTH-1:1]}
                              : {asm_q[WIDTH-2:0], serial_in};
        last_bit  = (bit_count_q == CW'(WIDTH - 1));
        out_free  = !data_valid_q || data_ready;

        state_d      = state_q;
        asm_d        = asm_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q && !data_ready;
        frame_err_d  = err_clr ? 1'b0 : frame_err_q;
        order_d      = order_q;
        bit_count_d  = bit_count_q;

        case (state_q)
            COLLECT: begin
                if (sync_clr) begin
                    bit_count_d = '0;
                    asm_d       = '0;
                    if (bit_count_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else if (accept) begin
                    asm_d   = shifted;
                    order_d = cur_order;
                    if (last_bit) begin
                        bit_count_d = '0;
                        if (out_free) begin
                            data_out_d   = shifted;
                            data_valid_d = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        bit_count_d = bit_count_q + CW'(1);
                    end
                end
            end
            STALL: begin
                // The held word only moves once the consumer takes the current one.
                if (data_ready) begin
                    data_out_d   = asm_q;
                    data_valid_d = 1'b1;
                    state_d      = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            asm_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            order_q      <= 1'b0;
            bit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            asm_q        <= asm_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            order_q      <= order_d;
            bit_count_q  <= bit_count_d;
        end
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: a 64-bit and an 8-bit instance share stimulus, one held in reset
// while the other runs; a queue of expected words is drained by a monitor on each handshake.
module tb_serial_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic sel8 = 1'b0;
    logic serial_in = 1'b0;
    logic serial_valid = 1'b0;
    logic shift_dir = 1'b0;
    logic sync_clr = 1'b0;
    logic err_clr = 1'b0;
    logic data_ready = 1'b0;

    logic        rst64, rst8;
    logic        sready64, sready8, dvalid64, dvalid8, ferr64, ferr8;
    logic [63:0] dout64;
    logic [7:0]  dout8;
    logic [6:0]  cnt64;
    logic [3:0]  cnt8;

    assign rst64 = rst | sel8;
    assign rst8  = rst | ~sel8;

    serial_deserializer #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst64), .serial_in(serial_in), .serial_valid(serial_valid),
        .serial_ready(sready64), .shift_dir(shift_dir), .sync_clr(sync_clr), .err_clr(err_clr),
        .data_out(dout64), .data_valid(dvalid64), .data_ready(data_ready),
        .bit_count(cnt64), .frame_err(ferr64)
    );

    serial_deserializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .serial_in(serial_in), .serial_valid(serial_valid),
        .serial_ready(sready8), .shift_dir(shift_dir), .sync_clr(sync_clr), .err_clr(err_clr),
        .data_out(dout8), .data_valid(dvalid8), .data_ready(data_ready),
        .bit_count(cnt8), .frame_err(ferr8)
    );

    // Everything below looks only at whichever instance is currently active.
    logic        act_sready, act_valid, act_ferr;
    logic [63:0] act_out;
    logic [6:0]  act_cnt;
    int          cur_w;

    always_comb begin
        act_sready = sel8 ? sready8 : sready64;
        act_valid  = sel8 ? dvalid8 : dvalid64;
        act_ferr   = sel8 ? ferr8 : ferr64;
        act_out    = sel8 ? {56'd0, dout8} : dout64;
        act_cnt    = sel8 ? {3'd0, cnt8} : cnt64;
        cur_w      = sel8 ? 8 : 64;
    end

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    bit          rand_mode = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (w=%0d): got %h, expected %h", name, cur_w, actual, expected);
        end
    endtask

    // Every consumed word must be the oldest outstanding one; a held word must not change.
    logic        hold_valid = 1'b0;
    logic [63:0] hold_val = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else begin
            if (hold_valid && act_valid) begin
                checkOutput("hold_stable", act_out, hold_val);
            end
            if (act_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", act_out, 64'hx);
                end else begin
                    checkOutput("word", act_out, exp_q.pop_front());
                end
            end
            hold_valid <= act_valid && !data_ready;
            hold_val   <= act_out;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (rand_mode) data_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic sendBit(input logic b);
        int  waited = 0;
        bit  ok;
        serial_in    = b;
        serial_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            ok = act_sready;
            stepCycle();
            if (ok) break;
            waited++;
            if (waited > 200) begin
                checkOutput("serial_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        serial_valid = 1'b0;
    endtask

    task automatic sendBits(input int n);
        for (int i = 0; i < n; i++) sendBit(1'($urandom_range(0, 1)));
    endtask

    function automatic logic [63:0] wordMask();
        return (cur_w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cur_w) - 64'd1);
    endfunction

    // Streams one word in the requested order; the expected word is simply the value itself.
    task automatic applyStimulus(input logic [63:0] value, input logic dir, input int toggle_at);
        logic [63:0] v;
        v = value & wordMask();
        exp_q.push_back(v);
        for (int i = 0; i < cur_w; i++) begin
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                serial_valid = 1'b0;
                serial_in    = 1'($urandom_range(0, 1));
                stepCycle();
            end
            shift_dir = (toggle_at >= 0 && i >= toggle_at) ? ~dir : dir;
            sendBit(dir ? v[i] : v[cur_w-1-i]);
        end
        shift_dir = dir;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic doReset(input bit use8);
        rst = 1'b1; sel8 = use8; serial_valid = 1'b0; sync_clr = 1'b0; err_clr = 1'b0;
        data_ready = 1'b0; shift_dir = 1'b0; rand_mode = 1'b0;
        exp_q.delete();
        waitCycles(2);
        checkOutput("rst_serial_ready", 64'(act_sready), 64'd0);
        checkOutput("rst_data_out", act_out, 64'd0);
        checkOutput("rst_data_valid", 64'(act_valid), 64'd0);
        checkOutput("rst_bit_count", 64'(act_cnt), 64'd0);
        checkOutput("rst_frame_err", 64'(act_ferr), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_serial_ready", 64'(act_sready), 64'd1);
    endtask

    task automatic orderTest(input logic [63:0] value, input logic dir);
        logic [63:0] v;
        v = value & wordMask();
        data_ready = 1'b1;
        shift_dir  = dir;
        exp_q.push_back(v);
        for (int i = 0; i < cur_w - 1; i++) sendBit(dir ? v[i] : v[cur_w-1-i]);
        checkOutput("order_valid_before_last", 64'(act_valid), 64'd0);
        checkOutput("order_count_before_last", 64'(act_cnt), 64'(cur_w - 1));
        sendBit(dir ? v[cur_w-1] : v[0]);
        checkOutput("order_valid_after_last", 64'(act_valid), 64'd1);
        checkOutput("order_data", act_out, v);
        checkOutput("order_count_wrap", 64'(act_cnt), 64'd0);
    endtask

    task automatic backpressureTest(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        data_ready = 1'b1;
        waitCycles(3);
        data_ready = 1'b0;
        applyStimulus(a, 1'b0, -1);
        checkOutput("bp_a_loaded", act_out, a & wordMask());
        applyStimulus(b, 1'b1, -1);
        checkOutput("bp_a_held", act_out, a & wordMask());
        checkOutput("bp_stall_ready", 64'(act_sready), 64'd0);
        sync_clr = 1'b1;
        stepCycle();
        sync_clr = 1'b0;
        checkOutput("bp_stall_syncclr_ferr", 64'(act_ferr), 64'd0);
        checkOutput("bp_still_stalled", 64'(act_sready), 64'd0);
        data_ready = 1'b1;
        stepCycle();
        data_ready = 1'b0;
        checkOutput("bp_b_loaded", act_out, b & wordMask());
        checkOutput("bp_b_valid", 64'(act_valid), 64'd1);
        checkOutput("bp_ready_back", 64'(act_sready), 64'd1);
        applyStimulus(c, 1'b0, -1);
        data_ready = 1'b1;
        waitCycles(4);
    endtask

    task automatic resyncTest();
        int n;
        n = sel8 ? 5 : 10;
        data_ready = 1'b1;
        sendBits(n);
        checkOutput("resync_count_before", 64'(act_cnt), 64'(n));
        serial_valid = 1'b1; serial_in = 1'b1; sync_clr = 1'b1;
        stepCycle();
        serial_valid = 1'b0; sync_clr = 1'b0;
        checkOutput("resync_count", 64'(act_cnt), 64'd0);
        checkOutput("resync_ferr_set", 64'(act_ferr), 64'd1);
        applyStimulus({$urandom, $urandom}, 1'b0, -1);
        waitCycles(2);
        err_clr = 1'b1;
        stepCycle();
        err_clr = 1'b0;
        checkOutput("resync_err_clr", 64'(act_ferr), 64'd0);
        sync_clr = 1'b1;
        stepCycle();
        sync_clr = 1'b0;
        checkOutput("resync_at_zero_ferr", 64'(act_ferr), 64'd0);
        sendBits(3);
        sync_clr = 1'b1; err_clr = 1'b1;
        stepCycle();
        sync_clr = 1'b0; err_clr = 1'b0;
        checkOutput("resync_set_beats_clr", 64'(act_ferr), 64'd1);
        err_clr = 1'b1;
        stepCycle();
        err_clr = 1'b0;
    endtask

    task automatic resetMidWordTest();
        data_ready = 1'b0;
        applyStimulus({$urandom, $urandom}, 1'b0, -1);
        sendBits(sel8 ? 3 : 30);
        checkOutput("midrst_valid_before", 64'(act_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_serial_ready", 64'(act_sready), 64'd0);
        exp_q.delete();
        stepCycle();
        checkOutput("midrst_data_out", act_out, 64'd0);
        checkOutput("midrst_data_valid", 64'(act_valid), 64'd0);
        checkOutput("midrst_bit_count", 64'(act_cnt), 64'd0);
        rst = 1'b0;
        data_ready = 1'b1;
        applyStimulus({$urandom, $urandom}, 1'b1, -1);
        waitCycles(2);
    endtask

    task automatic randomTest(input int words);
        int k;
        rand_mode = 1'b1;
        for (int w = 0; w < words; w++) begin
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(1, cur_w - 1);
                sendBits(k);
                sync_clr = 1'b1;
                stepCycle();
                sync_clr = 1'b0;
                checkOutput("rand_abort_ferr", 64'(act_ferr), 64'd1);
                err_clr = 1'b1;
                stepCycle();
                err_clr = 1'b0;
            end
            applyStimulus({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, cur_w - 1)) : -1);
        end
        rand_mode  = 1'b0;
        data_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) stepCycle();
        checkOutput("rand_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic runSuite(input bit use8);
        doReset(use8);
        orderTest(64'hDEADBEEF_CAFEF00D, 1'b0);
        orderTest(64'hDEADBEEF_CAFEF00D, 1'b1);
        data_ready = 1'b1;
        applyStimulus(64'hA5C3_0F96_1E2D_3C4B, 1'b0, use8 ? 3 : 20);
        waitCycles(2);
        if (use8) backpressureTest(64'h5A, 64'hC3, 64'h81);
        else backpressureTest(64'h01234567_89ABCDEF, 64'hFFFF0000_FFFF0000, 64'h13579BDF_2468ACE0);
        resyncTest();
        resetMidWordTest();
        randomTest(use8 ? 30 : 12);
    endtask

    initial begin
        runSuite(1'b0);
        runSuite(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
